// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_pkg                                                            |
// | Shared RV32I constants and the fetch queue entry type.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RV32I_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential successor of a word address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_unit_if                                                  |
// | Instruction memory request/grant bus with synchronous read data.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface instr_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo                                                           |
// | Synchronous DEPTH-entry queue of {pc, instr} with combinational head.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_unit                                                     |
// | Decoupled RV32I fetch: sequential word fetch, credit-limited queue,  |
// | redirect flush. Build option FETCH_BYPASS_EN forwards a response     |
// | straight to the outputs when the queue is empty.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                DATA_WIDTH = 32,
  parameter logic [XLEN-1:0]   RESET_PC   = RESET_PC_DEFAULT,
  parameter int                DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_unit_if.master    imem,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output logic                  valid_f,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  kill_q, kill_d;

  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     head;
  fetch_entry_t     rsp_entry;
  logic             rsp_valid;
  logic             bypass_hit;
  logic             pop;
  logic             fifo_pop;
  logic             push;
  logic             issue;
  logic             accept;
  logic [CNT_W:0]   credit_used;
  logic             redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];

  always_comb begin
    rsp_valid = inflight_q & ~kill_q;
    rsp_entry = '{pc: inflight_pc_q, instr: imem.imem_rdata};
`ifdef FETCH_BYPASS_EN
    bypass_hit = rsp_valid & (fifo_count == '0);
`else
    bypass_hit = 1'b0;
`endif
    head     = bypass_hit ? rsp_entry : fifo_head;
    valid_f  = (fifo_count != '0) | bypass_hit;
    pop      = valid_f & ~stall & ~redirect;
    fifo_pop = pop & ~bypass_hit;
    // A bypassed response consumed this cycle never occupies a slot.
    push     = rsp_valid & ~redirect & ~(bypass_hit & pop);

    // Outstanding work is queued entries plus the response still in flight.
    credit_used = {1'b0, fifo_count}
                + {{CNT_W{1'b0}}, inflight_q}
                - {{CNT_W{1'b0}}, pop};
    issue  = ~redirect & (credit_used < (CNT_W + 1)'(DEPTH));
    accept = issue & imem.imem_gnt;

    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    end else if (accept) begin
      pc_d = pc_next(pc_q);
    end
    inflight_d    = accept;
    inflight_pc_d = accept ? pc_q : inflight_pc_q;
    kill_d        = redirect & inflight_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      kill_q        <= kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign imem.imem_req  = issue & ~reset;
  assign imem.imem_addr = pc_q;

  // With nothing to present, PCF tracks the next fetch address.
  assign InstrF   = valid_f ? head.instr : RV32I_NOP;
  assign PCF      = valid_f ? head.pc    : pc_q;
  assign PCPlus4F = pc_next(PCF);

endmodule
`default_nettype wire
